seq_add_sub: RTL and testbench
==============================

Name: seq_add_sub

Overview:
Parametrised multi-cycle adder/subtractor for the ALU datapath. It processes DIGIT bits per clock, LSB digit first, with a start/busy/done handshake. It supports add or subtract with carry/borrow-in and produces result, carry-out and N/Z/V flags. It trades latency for area, giving the ALU a configurable-width arithmetic unit in place of a fixed 8-bit combinational adder.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥2 and a multiple of DIGIT (elaboration error otherwise).
DIGIT, 2, bits added per clock; DIGIT=WIDTH gives single-pass operation.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE or DONE.
op_sub  input  1  0 = a+b+cin; 1 = a−b−cin.
a  input  WIDTH  operand A, captured on accepted start.
b  input  WIDTH  operand B, captured on accepted start.
cin  input  1  carry-in (add) or borrow-in (sub).
busy  output  1  high while digits are being processed.
done  output  1  one-cycle pulse when result/flags update.
result  output  WIDTH  registered result; held until next done.
cout  output  1  add: carry-out; sub: 1 = no borrow (raw carry of a+~b+~cin).
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
neg  output  1  result[WIDTH-1].
zero  output  1  result == 0.

Behaviour:
- One clock; rst_n is asynchronous and active-low. Assertion immediately clears: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, neg=0, zero=0, and all internal operand/partial registers.
- FSM states:
  - IDLE --start--> RUN.
  - RUN: digit counter 0..N−1, N=WIDTH/DIGIT. At count N−1 --> DONE.
  - DONE --start--> RUN; otherwise DONE --> IDLE.
- Accept (edge E0, start=1 in IDLE/DONE): latch a; latch b XOR {WIDTH{op_sub}}; carry register = op_sub ? ~cin : cin; counter=0.
- RUN, each edge: add the low DIGIT bits of the A and B shift registers plus carry. Shift the sum digit into the top of the partial-result register. Shift A and B right by DIGIT. Update carry.
- Timing: busy=1 in the cycles after E0..E(N−1). Final digit at edge EN. In the cycle after EN: done=1, busy=0, and result/cout/ovf/neg/zero are updated together. done therefore rises exactly N cycles after the start edge.
- Outputs never show partial results; they are written only on the final-digit edge and held until the next final-digit edge.
- ovf: on the final digit, capture the sub-module's carry into the digit's top bit and the carry out; ovf = their XOR.
- start while busy is ignored and does not queue. start in the DONE cycle is accepted: back-to-back operations have zero idle gap.
- Inputs a, b, cin and op_sub may change freely after acceptance.
- rst_n asserted mid-RUN aborts the operation: no done pulse, and outputs read 0 after reset.
- DIGIT=WIDTH: N=1, done one cycle after start.
- All arithmetic is modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package alu_pkg:
  - state enum {ST_IDLE, ST_RUN, ST_DONE};
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1;
  - a function clog2 for the counter width (max(1, clog2(N))).
- Sub-module add_digit: parametrised DIGIT-bit ripple carry slice.
  - Inputs x, y, ci.
  - Outputs s, co, and c_top (carry into its MSB).
  - Purely combinational; instantiated once.

Test Plan:
- WIDTH=8, DIGIT=2, add 0x7F+0x01, cin=0 -> result=0x80, cout=0, ovf=1, neg=1, zero=0; done exactly 4 cycles after start edge; busy high for 4 cycles.
- Sub 0x05−0x05, cin=0 -> result=0x00, zero=1, cout=1, ovf=0. Then sub 0x00−0x01 -> result=0xFF, cout=0, neg=1, ovf=0.
- Add 0xFF+0x00, cin=1 -> 0x00, cout=1, zero=1. Sub 0x80−0x01 -> 0x7F, ovf=1, cout=1.
- Hold start high for 10 cycles with changing a/b -> first op completes with captured operands. A second op is accepted in the DONE cycle, and its done follows 4 cycles later. start pulses mid-RUN are ignored.
- Deassert rst_n asynchronously 2 cycles into RUN -> busy/done/result/flags read 0 immediately, with no done pulse. After release, 0x12+0x34 gives 0x46.
- Re-run the checks with WIDTH=16, DIGIT=4 (latency 4) and WIDTH=8, DIGIT=8 (latency 1). Add 1000 random vectors per configuration and compare against a reference model for result, cout, ovf, neg and zero.

Source files
------------

// File: rtl/seq_add_sub_pkg.sv
// Shared ALU definitions: sequencer states, operation encoding and a
// constant-evaluable log2 helper for sizing counters.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits needed to count 0..n-1, never less than one so a single-pass
  // configuration still gets a legal counter vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_add_sub_add_digit.sv
// One DIGIT-wide ripple-carry slice. Also exposes the carry into its MSB so
// the caller can form signed overflow on the most significant digit.
module add_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_top
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  // Full-adder chain, one bit per stage.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign co    = c[DIGIT];
  assign c_top = c[DIGIT-1];

endmodule

// File: rtl/seq_add_sub.sv
// Digit-serial adder/subtractor. Operands are captured on an accepted start,
// then DIGIT bits are summed per clock, LSB digit first. Result and flags
// are written only on the final digit and held until the next one.
module seq_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             neg,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  part_q, part_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              neg_q, neg_d;
  logic              zero_q, zero_d;

  logic              accept;
  logic              last_digit;
  logic [DIGIT-1:0]  sum_dig;
  logic              dig_co;
  logic              dig_ctop;
  logic [WIDTH-1:0]  part_shift;

  assign accept     = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_digit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  add_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (sum_dig),
    .co    (dig_co),
    .c_top (dig_ctop)
  );

  // New digit enters at the top; after N shifts the first digit sits at bit 0.
  assign part_shift = (part_q >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, digit stepping and final result/flag update.
  always_comb begin
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    if (accept) begin
      // Subtraction runs as a + ~b + ~cin so cout means "no borrow".
      a_d     = a;
      b_d     = b ^ {WIDTH{op_sub}};
      carry_d = (op_sub == OP_SUB) ? ~cin : cin;
      part_d  = '0;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = dig_co;
      part_d  = part_shift;
      cnt_d   = cnt_q + 1'b1;
      if (last_digit) begin
        result_d = part_shift;
        cout_d   = dig_co;
        ovf_d    = dig_ctop ^ dig_co;
        neg_d    = part_shift[WIDTH-1];
        zero_d   = (part_shift == '0);
      end
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign neg    = neg_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Drives three configurations (8/2, 16/4, 8/8) from one shared stimulus
// stream and checks each against an arithmetic reference model.
module tb_seq_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic        cin;
  logic [15:0] a_in;
  logic [15:0] b_in;

  logic [7:0]  r0;
  logic [15:0] r1;
  logic [7:0]  r2;
  logic [2:0]  busy_v, done_v, cout_v, ovf_v, neg_v, zero_v;

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(8), .DIGIT(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .result(r0), .cout(cout_v[0]),
    .ovf(ovf_v[0]), .neg(neg_v[0]), .zero(zero_v[0])
  );

  seq_add_sub #(.WIDTH(16), .DIGIT(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .a(a_in), .b(b_in), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .result(r1), .cout(cout_v[1]),
    .ovf(ovf_v[1]), .neg(neg_v[1]), .zero(zero_v[1])
  );

  seq_add_sub #(.WIDTH(8), .DIGIT(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .result(r2), .cout(cout_v[2]),
    .ovf(ovf_v[2]), .neg(neg_v[2]), .zero(zero_v[2])
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 1) ? 16 : 8;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 4 : (i == 1) ? 4 : 1;
  endfunction

  function automatic logic [15:0] res_of(input int i);
    case (i)
      0:       return {8'h00, r0};
      1:       return r1;
      default: return {8'h00, r2};
    endcase
  endfunction

  // Reference arithmetic: plain integer sums/differences and a signed range test.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input bit sub, input bit ci,
                                output logic [15:0] r, output bit co, output bit ov);
    longint m, ai, bi, half, u, sa, sb, s;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ai   = longint'(a) & m;
    bi   = longint'(b) & m;
    u    = sub ? (ai - bi - longint'(ci)) : (ai + bi + longint'(ci));
    r    = 16'(u & m);
    co   = sub ? (u >= 0) : (u > m);
    sa   = (ai >= half) ? ai - (m + 1) : ai;
    sb   = (bi >= half) ? bi - (m + 1) : bi;
    s    = sub ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
    ov   = (s >= half) || (s < -half);
  endfunction

  // Stimulus per clock edge of a sequence.
  logic [15:0] sa_v [40];
  logic [15:0] sb_v [40];
  bit          sop  [40];
  bit          scin [40];
  bit          sst  [40];

  // Last completed (visible) result per DUT.
  logic [15:0] lres [3];
  bit          lco  [3];
  bit          lov  [3];
  bit          lneg [3];
  bit          lzero[3];

  task automatic clear_last();
    for (int i = 0; i < 3; i++) begin
      lres[i] = '0; lco[i] = 0; lov[i] = 0; lneg[i] = 0; lzero[i] = 0;
    end
  endtask

  task automatic set_vec(input int j, input logic [15:0] a, input logic [15:0] b,
                         input bit sub, input bit ci, input bit st);
    sa_v[j] = a; sb_v[j] = b; sop[j] = sub; scin[j] = ci; sst[j] = st;
  endtask

  task automatic drive(input int j, input int len);
    if (j < len) begin
      a_in = sa_v[j]; b_in = sb_v[j]; op_sub = sop[j]; cin = scin[j]; start = sst[j];
    end else begin
      a_in = 16'($urandom); b_in = 16'($urandom);
      op_sub = 1'($urandom); cin = 1'($urandom); start = 1'b0;
    end
  endtask

  // Plays sst/sa_v/... for len edges and checks every DUT after every edge.
  // Must be entered mid-cycle with all DUTs idle.
  task automatic run_seq(input int len);
    int          next_acc [3];
    int          done_at  [3];
    logic [15:0] pr  [3];
    bit          pco [3];
    bit          pov [3];
    for (int i = 0; i < 3; i++) begin
      next_acc[i] = 0; done_at[i] = -1; pr[i] = '0; pco[i] = 0; pov[i] = 0;
    end
    drive(0, len);
    for (int k = 0; k < len + 6; k++) begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (k < len && sst[k] && k >= next_acc[i]) begin
          model(wid(i), sa_v[k], sb_v[k], sop[k], scin[k], pr[i], pco[i], pov[i]);
          done_at[i]  = k + lat(i);
          next_acc[i] = k + lat(i) + 1;
        end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("d%0d busy k%0d", i, k), 32'(busy_v[i]), 32'(k < done_at[i]));
        if (k == done_at[i]) begin
          check($sformatf("d%0d done k%0d", i, k), 32'(done_v[i]), 32'd1);
          check($sformatf("d%0d result", i), 32'(res_of(i)), 32'(pr[i]));
          check($sformatf("d%0d cout", i), 32'(cout_v[i]), 32'(pco[i]));
          check($sformatf("d%0d ovf", i), 32'(ovf_v[i]), 32'(pov[i]));
          check($sformatf("d%0d neg", i), 32'(neg_v[i]), 32'(pr[i][wid(i)-1]));
          check($sformatf("d%0d zero", i), 32'(zero_v[i]), 32'(pr[i] == 16'h0));
          lres[i] = pr[i]; lco[i] = pco[i]; lov[i] = pov[i];
          lneg[i] = pr[i][wid(i)-1]; lzero[i] = (pr[i] == 16'h0);
        end else begin
          check($sformatf("d%0d done k%0d", i, k), 32'(done_v[i]), 32'd0);
          check($sformatf("d%0d hold result", i), 32'(res_of(i)), 32'(lres[i]));
          check($sformatf("d%0d hold flags", i),
                {28'h0, cout_v[i], ovf_v[i], neg_v[i], zero_v[i]},
                {28'h0, lco[i], lov[i], lneg[i], lzero[i]});
        end
      end
      drive(k + 1, len);
    end
  endtask

  task automatic single(input logic [15:0] a, input logic [15:0] b, input bit sub, input bit ci);
    set_vec(0, a, b, sub, ci, 1'b1);
    run_seq(1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d %s outputs", i, tag),
            {res_of(i), 10'h0, busy_v[i], done_v[i], cout_v[i], ovf_v[i], neg_v[i], zero_v[i]},
            32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
    clear_last();
    #12;
    check_all_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed boundary cases.
    single(16'h007F, 16'h0001, 1'b0, 1'b0);
    single(16'h0005, 16'h0005, 1'b1, 1'b0);
    single(16'h0000, 16'h0001, 1'b1, 1'b0);
    single(16'h00FF, 16'h0000, 1'b0, 1'b1);
    single(16'h0080, 16'h0001, 1'b1, 1'b0);
    single(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    single(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    single(16'h8000, 16'h0001, 1'b1, 1'b0);

    // Start held for ten edges with operands changing every cycle.
    for (int j = 0; j < 10; j++)
      set_vec(j, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    run_seq(10);

    // Start pulses landing mid-run.
    for (int j = 0; j < 8; j++)
      set_vec(j, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), (j % 2) == 0);
    run_seq(8);

    // Asynchronous reset two cycles into a run.
    set_vec(0, 16'h00AB, 16'h0011, 1'b0, 1'b0, 1'b1);
    a_in = sa_v[0]; b_in = sb_v[0]; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    clear_last();
    @(posedge clk); #1;
    check_all_zero("in reset");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        check($sformatf("d%0d no done after reset", i), 32'(done_v[i]), 32'd0);
    end
    single(16'h0012, 16'h0034, 1'b0, 1'b0);

    // Random single operations.
    for (int t = 0; t < 500; t++)
      single(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    // Random start patterns, including back-to-back acceptance in DONE.
    for (int t = 0; t < 300; t++) begin
      for (int j = 0; j < 12; j++)
        set_vec(j, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3) != 0);
      run_seq(12);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
